// File: rtl/debounce_edge.sv
// Multi-channel pin conditioner: 2-flop synchroniser, per-channel persistence
// counter, registered stable level with one-cycle rise/fall pulses.
`timescale 1ns/1ps

module debounce_edge #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         any_edge
);

    localparam int unsigned     CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]         sync1;
    logic [N-1:0]         sync2;
    logic [N-1:0]         mismatch;
    logic [N-1:0][CW-1:0] cnt;
    logic [N-1:0][CW-1:0] cnt_nxt;
    logic [N-1:0]         level_nxt;
    logic [N-1:0]         rise_nxt;
    logic [N-1:0]         fall_nxt;
    logic                 any_edge_nxt;

    always_comb begin
        mismatch = sync2 ^ level;
    end

    // The terminal compare always clears the count, so it can never wrap.
    always_comb begin
        level_nxt = level;
        rise_nxt  = '0;
        fall_nxt  = '0;
        cnt_nxt   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (mismatch[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = sync2[i];
                    rise_nxt[i]  = sync2[i];
                    fall_nxt[i]  = ~sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
        any_edge_nxt = |(rise_nxt | fall_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            cnt      <= '0;
            level    <= '0;
            rise     <= '0;
            fall     <= '0;
            any_edge <= 1'b0;
        end else begin
            sync1    <= din;
            sync2    <= sync1;
            cnt      <= cnt_nxt;
            level    <= level_nxt;
            rise     <= rise_nxt;
            fall     <= fall_nxt;
            any_edge <= any_edge_nxt;
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed self-checking bench for debounce_edge (N=2, DEBOUNCE_CYCLES=4 and 1).
`timescale 1ns/1ps

module tb_debounce_edge;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [1:0] din;
    logic [1:0] level, rise, fall;
    logic       any_edge;
    logic [1:0] din1;
    logic [1:0] level1, rise1, fall1;
    logic       any_edge1;

    int checks = 0;
    int errors = 0;

    debounce_edge #(.N(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din),
        .level(level), .rise(rise), .fall(fall), .any_edge(any_edge)
    );

    debounce_edge #(.N(2), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1),
        .level(level1), .rise(rise1), .fall(fall1), .any_edge(any_edge1)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns 3 time units before the next rising edge, with all inputs low.
    task automatic do_reset;
        @(negedge clk);
        din   = '0;
        din1  = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        din   = 2'b11;
        din1  = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({level, rise, fall, any_edge} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async: got lvl=%b r=%b f=%b a=%b required all 0", level, rise, fall, any_edge);
        end
        checks++;
        if ({level1, rise1, fall1, any_edge1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async_d1: got lvl=%b r=%b f=%b a=%b required all 0", level1, rise1, fall1, any_edge1);
        end
        din    = '0;
        din1   = '0;
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({level, rise, fall, any_edge, level1, rise1, fall1, any_edge1} !== 14'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d: got lvl=%b r=%b f=%b a=%b lvl1=%b required all 0",
                         k, level, rise, fall, any_edge, level1);
            end
        end
    endtask

    task automatic test_clean_press;
        logic [1:0] exp_lvl, exp_rise;
        do_reset();
        din = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lvl  = (k >= 6) ? 2'b01 : 2'b00;
            exp_rise = (k == 6) ? 2'b01 : 2'b00;
            checks++;
            if (level !== exp_lvl || rise !== exp_rise || fall !== 2'b00 || any_edge !== (k == 6)) begin
                errors++;
                $display("FAIL clean_press k=%0d: got lvl=%b r=%b f=%b a=%b required lvl=%b r=%b f=00 a=%b",
                         k, level, rise, fall, any_edge, exp_lvl, exp_rise, (k == 6));
            end
        end
    endtask

    task automatic test_glitch;
        logic [1:0] exp_lvl, exp_rise, exp_fall;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            din = (k <= 3) ? 2'b01 : 2'b00;
            tick();
            checks++;
            if (level !== 2'b00 || rise !== 2'b00 || fall !== 2'b00 || any_edge !== 1'b0) begin
                errors++;
                $display("FAIL glitch3 k=%0d: got lvl=%b r=%b f=%b a=%b required all 0", k, level, rise, fall, any_edge);
            end
        end
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            din = (k <= 4) ? 2'b01 : 2'b00;
            tick();
            exp_lvl  = (k >= 6 && k <= 9) ? 2'b01 : 2'b00;
            exp_rise = (k == 6) ? 2'b01 : 2'b00;
            exp_fall = (k == 10) ? 2'b01 : 2'b00;
            checks++;
            if (level !== exp_lvl || rise !== exp_rise || fall !== exp_fall) begin
                errors++;
                $display("FAIL glitch4 k=%0d: got lvl=%b r=%b f=%b required lvl=%b r=%b f=%b",
                         k, level, rise, fall, exp_lvl, exp_rise, exp_fall);
            end
        end
    endtask

    task automatic test_bounce;
        logic [4:0] pattern;
        logic [1:0] exp_lvl, exp_rise;
        int         n_rise;
        pattern = 5'b10101;
        n_rise  = 0;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            din = (k <= 5) ? {pattern[k-1], 1'b0} : 2'b10;
            tick();
            if (rise[1]) n_rise++;
            exp_lvl  = (k >= 10) ? 2'b10 : 2'b00;
            exp_rise = (k == 10) ? 2'b10 : 2'b00;
            checks++;
            if (level !== exp_lvl || rise !== exp_rise || fall !== 2'b00) begin
                errors++;
                $display("FAIL bounce k=%0d: got lvl=%b r=%b f=%b required lvl=%b r=%b f=00",
                         k, level, rise, fall, exp_lvl, exp_rise);
            end
        end
        checks++;
        if (n_rise != 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d rise pulses required 1", n_rise);
        end
    endtask

    task automatic test_simultaneous;
        logic [1:0] exp_lvl, exp_fall;
        do_reset();
        din = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) begin
                checks++;
                if (level !== 2'b11 || rise !== 2'b11 || any_edge !== 1'b1) begin
                    errors++;
                    $display("FAIL sim_press: got lvl=%b r=%b a=%b required lvl=11 r=11 a=1", level, rise, any_edge);
                end
            end
        end
        din = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lvl  = (k >= 6) ? 2'b00 : 2'b11;
            exp_fall = (k == 6) ? 2'b11 : 2'b00;
            checks++;
            if (level !== exp_lvl || fall !== exp_fall || rise !== 2'b00 || any_edge !== (k == 6)) begin
                errors++;
                $display("FAIL sim_release k=%0d: got lvl=%b r=%b f=%b a=%b required lvl=%b r=00 f=%b a=%b",
                         k, level, rise, fall, any_edge, exp_lvl, exp_fall, (k == 6));
            end
        end
    endtask

    task automatic test_reset_mid_count;
        logic [1:0] exp_lvl, exp_rise;
        do_reset();
        din = 2'b10;
        for (int k = 1; k <= 6; k++) tick();
        din = 2'b11;
        for (int k = 1; k <= 5; k++) tick();
        checks++;
        if (level !== 2'b10 || rise !== 2'b00) begin
            errors++;
            $display("FAIL mid_pre: got lvl=%b r=%b required lvl=10 r=00", level, rise);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (level !== 2'b00 || rise !== 2'b00 || fall !== 2'b00 || any_edge !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got lvl=%b r=%b f=%b a=%b required all 0", level, rise, fall, any_edge);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_lvl  = (k >= 6) ? 2'b11 : 2'b00;
            exp_rise = (k == 6) ? 2'b11 : 2'b00;
            checks++;
            if (level !== exp_lvl || rise !== exp_rise || fall !== 2'b00) begin
                errors++;
                $display("FAIL mid_restart k=%0d: got lvl=%b r=%b f=%b required lvl=%b r=%b f=00",
                         k, level, rise, fall, exp_lvl, exp_rise);
            end
        end
    endtask

    task automatic test_min_param;
        logic [1:0] exp_lvl, exp_rise, exp_fall;
        do_reset();
        din1 = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_lvl  = (k >= 3) ? 2'b01 : 2'b00;
            exp_rise = (k == 3) ? 2'b01 : 2'b00;
            checks++;
            if (level1 !== exp_lvl || rise1 !== exp_rise || fall1 !== 2'b00 || any_edge1 !== (k == 3)) begin
                errors++;
                $display("FAIL min_press k=%0d: got lvl=%b r=%b f=%b a=%b required lvl=%b r=%b f=00 a=%b",
                         k, level1, rise1, fall1, any_edge1, exp_lvl, exp_rise, (k == 3));
            end
        end
        din1 = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_lvl  = (k >= 3) ? 2'b10 : 2'b01;
            exp_rise = (k == 3) ? 2'b10 : 2'b00;
            exp_fall = (k == 3) ? 2'b01 : 2'b00;
            checks++;
            if (level1 !== exp_lvl || rise1 !== exp_rise || fall1 !== exp_fall || any_edge1 !== (k == 3)) begin
                errors++;
                $display("FAIL min_swap k=%0d: got lvl=%b r=%b f=%b a=%b required lvl=%b r=%b f=%b a=%b",
                         k, level1, rise1, fall1, any_edge1, exp_lvl, exp_rise, exp_fall, (k == 3));
            end
        end
    endtask

    initial begin
        clk    = 1'b0;
        clk_en = 1'b0;
        rst_n  = 1'b1;
        din    = '0;
        din1   = '0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_min_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Multi-channel input conditioner for the raw push-button/switch pins of the board design.
- Per channel: synchronises the raw pin, then runs a per-bit not-equal compare between the synchronised sample and the current debounced level.
- The stable level flips only after the mismatch has persisted long enough.
- Outputs the clean level plus one-cycle rise/fall pulses consumed by downstream control FSMs and counters.

Parameters:
- N, 4, number of independent input channels (>=1)
- DEBOUNCE_CYCLES, 200000, consecutive mismatching clock cycles required before the stable level flips (>=1; 2 ms at 100 MHz)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  N  raw asynchronous pin levels
- level  output  N  debounced stable level per channel
- rise  output  N  one-cycle pulse when level goes 0->1
- fall  output  N  one-cycle pulse when level goes 1->0
- any_edge  output  1  OR of all rise|fall bits, same cycle

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: rst_n low clears all state immediately, without waiting for a clock edge.
  - Cleared: sync stages, counters, level, rise, fall, any_edge all go to 0.
  - Release is sampled at the next clk rising edge.
  - Reset asserted mid-count discards all progress; no pulse is emitted.
- Synchroniser: 2 flops per bit, sync1 <= din and sync2 <= sync1.
- Mismatch: mismatch[i] = (sync2[i] != level[i]), combinational.
- Counter, per channel, width = clog2(DEBOUNCE_CYCLES), minimum 1 bit. Each edge, exactly one of:
  - mismatch and cnt == DEBOUNCE_CYCLES-1: level toggles, cnt <= 0, and rise or fall (matching the new level) <= 1.
  - mismatch and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - no mismatch: cnt <= 0, i.e. any agreement cycle restarts the count.
- Pulses: rise/fall are registered and high for exactly one cycle, coincident with the level change.
  - rise[i] and fall[i] are never high together.
  - any_edge is registered from the same next-state values, so it is coincident with the pulses.
- Latency: din changes and is captured at edge E0, reaches sync2 at E1, and level flips at edge E0+DEBOUNCE_CYCLES+1 if din is held.
  - DEBOUNCE_CYCLES=1 gives a 2-edge latency.
- Glitch rejection: din held for fewer than DEBOUNCE_CYCLES cycles produces no change.
  - Held for exactly DEBOUNCE_CYCLES cycles is accepted.
- Channels are fully independent. Simultaneous flips on several channels each pulse in the same cycle, and any_edge is a single pulse.
- Counters never wrap: the count saturates by design because the compare at DEBOUNCE_CYCLES-1 always clears it.
- Implementation intent: no latches, no combinational path from din to any output.

Test Plan (N=2, DEBOUNCE_CYCLES=4 unless noted):
- Reset: rst_n=0 with din=2'b11, no clock running -> level, rise, fall, any_edge are 0 immediately. Release rst_n with din=0 -> outputs stay 0 for 20 cycles.
- Clean press: din[0] 0->1 before edge E0 and held -> level[0]=1 and rise[0]=1 after E5. rise[0]=0 after E6. fall and level[1] stay 0; any_edge pulses with rise[0].
- Glitch: din[0]=1 for 3 cycles, then 0 -> level[0] never changes, no pulses. Repeat with 4 cycles -> level[0] flips and rise[0] pulses once.
- Bounce: din[1] toggles 1,0,1,0,1 each cycle, then holds 1 -> exactly one rise[1], 5 edges after the final 0->1 capture.
- Release and simultaneous: level=2'b11, then din 11->00 on the same edge -> fall=2'b11 for one cycle, any_edge=1 for one cycle, level=00.
- Reset mid-count and min parameter: with cnt at 3, pulse rst_n low between edges -> immediate clear, no pulse. Rerun with DEBOUNCE_CYCLES=1 -> level follows din at 2 edges.
